// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo ramp controller.
//   servo_state_e : ramp FSM state (idle at target / ramping toward target)
//   Def*          : default frame period and pulse-width limits (50 MHz clock)
//   clamp_pw()    : limit a requested pulse width to [lo, hi]
package servo_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRamp = 1'b1
  } servo_state_e;

  localparam int unsigned DefFrameCycles = 1000000;
  localparam int unsigned DefMinPw       = 50000;
  localparam int unsigned DefMaxPw       = 100000;
  localparam int unsigned DefCenterPw    = (DefMinPw + DefMaxPw) / 2;
  localparam int unsigned DefW           = 20;

  function automatic int unsigned clamp_pw(input int unsigned value,
                                           input int unsigned lo,
                                           input int unsigned hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Command channel into the servo ramp controller (valid/ready handshake).
//   cmd_valid  : command present (master -> slave)
//   cmd_ready  : command accepted this cycle (slave -> master)
//   cmd_target : requested pulse width in clock cycles
//   cmd_step   : maximum pulse-width change per frame, 0 = jump in one frame
interface servo_ramp_ctrl_if #(
  parameter int unsigned W = 20
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_target;
  logic [W-1:0] cmd_step;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/servo_frame_timer.sv
// PWM frame counter.
//   clock_clk  : system clock
//   reset_low  : synchronous active-low reset
//   enable     : 1 = count frames, 0 = hold the counter at 0
//   frame_cnt  : position within the current frame, 0..FRAME_CYCLES-1
//   frame_tick : high on the last cycle of each frame while enabled
module servo_frame_timer #(
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned W            = 20
) (
  input  logic         clock_clk,
  input  logic         reset_low,
  input  logic         enable,
  output logic [W-1:0] frame_cnt,
  output logic         frame_tick
);

  localparam logic [W-1:0] LastCnt = W'(FRAME_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (!enable || (cnt_q == LastCnt)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_low) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign frame_cnt  = cnt_q;
  assign frame_tick = enable && (cnt_q == LastCnt);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Slew-limited servo PWM controller. Accepts a target pulse width and a
// per-frame step limit, then walks the active pulse width toward the target
// one frame boundary at a time so no pulse is ever cut short.
//   clock_clk  : system clock
//   reset_low  : synchronous active-low reset
//   enable     : 1 = generate frames, 0 = output parked low, ramp frozen
//   cmd        : command channel (slave side)
//   pwm_out    : registered servo drive
//   frame_tick : last cycle of each frame
//   busy       : ramp in progress
//   at_target  : inverse of busy
//   cur_pw     : pulse width in effect for the current frame
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = DefFrameCycles,
  parameter int unsigned MIN_PW       = DefMinPw,
  parameter int unsigned MAX_PW       = DefMaxPw,
  parameter int unsigned W            = DefW
) (
  input  logic                clock_clk,
  input  logic                reset_low,
  input  logic                enable,
  servo_ramp_ctrl_if.slave    cmd,
  output logic                pwm_out,
  output logic                frame_tick,
  output logic                busy,
  output logic                at_target,
  output logic [W-1:0]        cur_pw
);

  localparam logic [W-1:0] CenterPw = W'((MIN_PW + MAX_PW) / 2);

  logic [W-1:0] frame_cnt;
  logic         xfer;
  logic [W-1:0] tgt_clamped;
  logic [W:0]   up_sum;
  logic [W:0]   down_diff;

  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] step_q, step_d;
  logic         pwm_q, pwm_d;
  servo_state_e state_q, state_d;

  servo_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .W            (W)
  ) u_frame_timer (
    .clock_clk  (clock_clk),
    .reset_low  (reset_low),
    .enable     (enable),
    .frame_cnt  (frame_cnt),
    .frame_tick (frame_tick)
  );

  assign cmd.cmd_ready = reset_low;
  assign xfer          = cmd.cmd_valid && cmd.cmd_ready;

  // Datapath: boundary update always works from the registered tgt/step, so a
  // command landing on the tick cycle only affects the following boundary.
  always_comb begin
    tgt_clamped = W'(clamp_pw(32'(cmd.cmd_target), MIN_PW, MAX_PW));
    up_sum      = {1'b0, cur_q} + {1'b0, step_q};
    down_diff   = {1'b0, cur_q} - {1'b0, tgt_q};

    cur_d = cur_q;
    if (frame_tick) begin
      if (step_q == '0) begin
        cur_d = tgt_q;
      end else if (cur_q < tgt_q) begin
        cur_d = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[W-1:0];
      end else if (cur_q > tgt_q) begin
        cur_d = (down_diff <= {1'b0, step_q}) ? tgt_q : (cur_q - step_q);
      end
    end

    tgt_d  = xfer ? tgt_clamped : tgt_q;
    step_d = xfer ? cmd.cmd_step : step_q;
    pwm_d  = enable && (frame_cnt < cur_q);
  end

  // Ramp FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (xfer && (tgt_d != cur_d)) state_d = StRamp;
      end
      StRamp: begin
        if (xfer) begin
          state_d = (tgt_d == cur_d) ? StIdle : StRamp;
        end else if (frame_tick && (cur_d == tgt_q)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_low) begin
      cur_q   <= CenterPw;
      tgt_q   <= CenterPw;
      step_q  <= '0;
      pwm_q   <= 1'b0;
      state_q <= StIdle;
    end else begin
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      pwm_q   <= pwm_d;
      state_q <= state_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign cur_pw    = cur_q;
  assign busy      = (state_q == StRamp);
  assign at_target = (state_q != StRamp);

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
module tb_servo_ramp_ctrl;

  localparam int unsigned FrameCycles = 100;
  localparam int unsigned MinPw       = 10;
  localparam int unsigned MaxPw       = 20;
  localparam int unsigned Wd          = 8;

  logic          clock_clk = 1'b0;
  logic          reset_low;
  logic          enable;
  logic          pwm_out;
  logic          frame_tick;
  logic          busy;
  logic          at_target;
  logic [Wd-1:0] cur_pw;

  servo_ramp_ctrl_if #(.W(Wd)) cmd_bus ();

  servo_ramp_ctrl #(
    .FRAME_CYCLES (FrameCycles),
    .MIN_PW       (MinPw),
    .MAX_PW       (MaxPw),
    .W            (Wd)
  ) dut (
    .clock_clk  (clock_clk),
    .reset_low  (reset_low),
    .enable     (enable),
    .cmd        (cmd_bus.slave),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick),
    .busy       (busy),
    .at_target  (at_target),
    .cur_pw     (cur_pw)
  );

  always #5 clock_clk = ~clock_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pulse width in effect, target and step, updated per frame.
  int m_cur;
  int m_tgt;
  int m_step;

  function automatic int clamp_ref(input int t);
    if (t < int'(MinPw)) return int'(MinPw);
    if (t > int'(MaxPw)) return int'(MaxPw);
    return t;
  endfunction

  function automatic int ramp_ref(input int cur, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
    if (cur > tgt) return (cur - stp < tgt) ? tgt : cur - stp;
    return cur;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clock_clk);
    #1;
  endtask

  // Runs one whole frame starting at frame_cnt == 0. Optionally presents a
  // command at sample offset cmd_at (1..99); it transfers on the next edge.
  task automatic run_frame(input string tag, input int cmd_at, input int tgt, input int stp);
    int w;
    int highs;
    int ticks;
    int tick_at;
    int xfer_k;
    w       = m_cur;
    highs   = 0;
    ticks   = 0;
    tick_at = -1;
    xfer_k  = -1;
    for (int k = 1; k <= int'(FrameCycles); k++) begin
      step_clk();
      if (cmd_bus.cmd_valid) begin
        cmd_bus.cmd_valid = 1'b0;
        xfer_k = k;
        if (k < int'(FrameCycles)) begin
          m_tgt  = clamp_ref(tgt);
          m_step = stp;
          check({tag, ":busy_xfer"}, 32'(busy), 32'(m_cur != m_tgt));
        end
      end
      if (pwm_out === 1'b1) highs++;
      if (frame_tick === 1'b1) begin
        ticks++;
        tick_at = k;
      end
      if (k == cmd_at) begin
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_target = Wd'(tgt);
        cmd_bus.cmd_step   = Wd'(stp);
      end
    end
    check({tag, ":width"}, 32'(highs), 32'(w));
    check({tag, ":ticks"}, 32'(ticks), 32'd1);
    check({tag, ":tick_at"}, 32'(tick_at), 32'(FrameCycles - 1));
    m_cur = ramp_ref(m_cur, m_tgt, m_step);
    if (xfer_k == int'(FrameCycles)) begin
      m_tgt  = clamp_ref(tgt);
      m_step = stp;
    end
    check({tag, ":cur_pw"}, 32'(cur_pw), 32'(m_cur));
    check({tag, ":busy"}, 32'(busy), 32'(m_cur != m_tgt));
    check({tag, ":at_target"}, 32'(at_target), 32'(m_cur == m_tgt));
  endtask

  initial begin
    int highs;
    int r_at;
    int r_tgt;
    int r_stp;

    reset_low          = 1'b0;
    enable             = 1'b1;
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_target = '0;
    cmd_bus.cmd_step   = '0;

    // 1. Reset state, then idle frames at the centre width.
    step_clk();
    step_clk();
    check("rst:cmd_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    check("rst:pwm_out", 32'(pwm_out), 32'd0);
    check("rst:frame_tick", 32'(frame_tick), 32'd0);
    check("rst:cur_pw", 32'(cur_pw), 32'd15);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:at_target", 32'(at_target), 32'd1);
    reset_low = 1'b1;
    #1;
    check("rst:cmd_ready_rel", 32'(cmd_bus.cmd_ready), 32'd1);
    m_cur  = 15;
    m_tgt  = 15;
    m_step = 0;
    run_frame("idle0", -1, 0, 0);
    run_frame("idle1", -1, 0, 0);

    // 2. Ramp up 15 -> 17 -> 19 -> 20 with step 2.
    run_frame("up0", 30, 20, 2);
    run_frame("up1", -1, 0, 0);
    run_frame("up2", -1, 0, 0);
    run_frame("up3", -1, 0, 0);

    // 3. Below-minimum target with step 0: single-frame jump to MIN.
    run_frame("jump0", 10, 5, 0);
    run_frame("jump1", -1, 0, 0);

    // 4. Command on the tick cycle during a ramp.
    run_frame("tick0", 50, 20, 3);
    run_frame("tick1", 99, 12, 1);
    run_frame("tick2", -1, 0, 0);

    // 5. Disable mid-pulse, then re-enable for a full-width pulse.
    step_clk();
    step_clk();
    step_clk();
    check("dis:pwm_before", 32'(pwm_out), 32'd1);
    enable = 1'b0;
    step_clk();
    check("dis:pwm_off", 32'(pwm_out), 32'd0);
    check("dis:frame_tick", 32'(frame_tick), 32'd0);
    check("dis:cur_pw", 32'(cur_pw), 32'(m_cur));
    highs = 0;
    for (int k = 0; k < 150; k++) begin
      step_clk();
      if (pwm_out !== 1'b0 || frame_tick !== 1'b0) highs++;
    end
    check("dis:quiet", 32'(highs), 32'd0);
    check("dis:cur_frozen", 32'(cur_pw), 32'(m_cur));
    enable = 1'b1;
    run_frame("reen", -1, 0, 0);

    // 6. Reset mid-ramp and mid-pulse.
    step_clk();
    step_clk();
    step_clk();
    step_clk();
    step_clk();
    check("rr:busy_before", 32'(busy), 32'd1);
    check("rr:pwm_before", 32'(pwm_out), 32'd1);
    reset_low = 1'b0;
    #1;
    check("rr:cmd_ready_low", 32'(cmd_bus.cmd_ready), 32'd0);
    step_clk();
    check("rr:pwm_out", 32'(pwm_out), 32'd0);
    check("rr:cur_pw", 32'(cur_pw), 32'd15);
    check("rr:busy", 32'(busy), 32'd0);
    check("rr:at_target", 32'(at_target), 32'd1);
    check("rr:frame_tick", 32'(frame_tick), 32'd0);
    reset_low = 1'b1;
    #1;
    check("rr:cmd_ready_rel", 32'(cmd_bus.cmd_ready), 32'd1);
    m_cur  = 15;
    m_tgt  = 15;
    m_step = 0;
    run_frame("rr_frame", -1, 0, 0);

    // Randomized commands against the reference model.
    for (int f = 0; f < 30; f++) begin
      r_at  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 99));
      r_tgt = ($urandom_range(0, 4) == 0) ? m_cur : int'($urandom_range(0, 40));
      r_stp = int'($urandom_range(0, 6));
      run_frame($sformatf("rnd%0d", f), r_at, r_tgt, r_stp);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_ramp_ctrl.md
Name: servo_ramp_ctrl

Overview:
Slew-limited position controller for a single hobby servo or similar PWM actuator on the forklift.
- Accepts target pulse-width commands through a valid/ready handshake.
- Generates the fixed-period PWM frame.
- Moves the active pulse width toward the target by at most a programmable step per frame.
- Applies changes only at frame boundaries, so no pulse is ever truncated or glitched.
- Sits between the software-facing register/bridge logic and the servo output pin.

Parameters:
- FRAME_CYCLES, 1000000, PWM period in clock cycles (20 ms at 50 MHz).
- MIN_PW, 50000, minimum legal pulse width in cycles (1 ms).
- MAX_PW, 100000, maximum legal pulse width in cycles (2 ms).
- W, 20, width of counters and pulse-width values; must hold FRAME_CYCLES-1.

Ports:
- clock_clk  in  1  system clock.
- reset_low  in  1  synchronous active-low reset. One clock; reset is sampled on the rising edge of clock_clk only.
- enable  in  1  1 = generate frames; 0 = output parked low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_target  in  W  requested pulse width in cycles.
- cmd_step  in  W  maximum change per frame; 0 means jump in one frame.
- pwm_out  out  1  servo drive, registered.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.
- busy  out  1  ramp in progress (cur_pw != tgt_pw).
- at_target  out  1  inverse of busy.
- cur_pw  out  W  pulse width in effect for the current frame.

Behaviour:
- Reset (reset_low=0 at a clock edge):
  - frame_cnt = 0; cur_pw = tgt_pw = (MIN_PW+MAX_PW)/2; step_r = 0.
  - state = IDLE; pwm_out = 0; frame_tick = 0; busy = 0; at_target = 1.
  - cmd_ready = 0 while reset_low=0, and 1 from the first cycle after release.
- Reset mid-ramp or mid-pulse: aborts immediately; pwm_out = 0 on the next edge. No pending state survives.
- Frame counter:
  - While enable=1, increments each cycle, 0..FRAME_CYCLES-1, then wraps to 0.
  - While enable=0, held at 0; cur_pw and tgt_pw are frozen; commands are still accepted.
  - On re-enable, the frame starts at count 0.
- PWM:
  - pwm_out <= enable && (frame_cnt < cur_pw). One-cycle registered latency; high for exactly cur_pw cycles per frame.
- Command handshake:
  - cmd_ready = 1 whenever out of reset. Transfer occurs when cmd_valid && cmd_ready.
  - On transfer: tgt_pw <= clamp(cmd_target, MIN_PW, MAX_PW); step_r <= cmd_step.
  - A later command overwrites an earlier one; the last command wins.
- Frame boundary (frame_tick=1, i.e. frame_cnt == FRAME_CYCLES-1, enable=1):
  - if cur < tgt: cur <= min(cur+step_r, tgt).
  - if cur > tgt: cur <= max(cur-step_r, tgt).
  - if step_r == 0: cur <= tgt.
  - Arithmetic is done at W+1 bits, so there is no overflow or underflow.
  - The new cur_pw takes effect from frame_cnt = 0 of the next frame.
- Simultaneous command and boundary: the boundary update uses the old tgt_pw/step_r. The new command affects the following boundary.
- FSM:
  - IDLE: cur == tgt. Goes to RAMP when a transfer produces tgt != cur.
  - RAMP: goes to IDLE at the boundary where cur reaches tgt, or on any cycle when a transfer sets tgt == cur.
  - busy = (state == RAMP).
- Clamp boundaries: a target below MIN_PW becomes MIN_PW; a target above MAX_PW becomes MAX_PW. cur_pw never leaves [MIN_PW, MAX_PW].

Decomposition:
- Package servo_pkg:
  - State enum {IDLE, RAMP}.
  - Default constants for frame period, MIN/MAX pulse width, center value.
  - Clamp helper function.
- Sub-module servo_frame_timer:
  - Contains the frame counter, wrap logic, enable hold and frame_tick generation.
  - Instantiated once.
- All other logic (handshake, target/step registers, ramp arithmetic, FSM, PWM compare) lives in servo_ramp_ctrl.

Test Plan:
Benches use FRAME_CYCLES=100, MIN_PW=10, MAX_PW=20, W=8.
1. Reset, enable=1 -> cur_pw=15, pwm_out high 15 cycles per 100-cycle frame, busy=0, frame_tick every 100 cycles.
2. Command target=20, step=2 mid-frame -> busy=1 at once. cur_pw goes 17, 19, 20 on the next three boundaries. busy drops at the third boundary. Pulse widths are 15, 17, 19, 20.
3. target=5 (below MIN), step=0 -> clamped to 10. cur_pw=10 after the next boundary, which is a single-frame jump.
4. Command presented on the frame_tick cycle during a ramp (target=12, step=1) -> that boundary still applies the old step/target. The new ramp starts at the following boundary.
5. enable=0 mid-pulse -> pwm_out=0 next cycle, frame_cnt held at 0, cur_pw frozen. After re-enable, the pulse starts at the next cycle with the full width.
6. reset_low=0 for 1 cycle mid-ramp -> next edge gives pwm_out=0, cur_pw=15, busy=0. cmd_ready=0 during reset and 1 after.
